axi_s2mm_interface: RTL and testbench
=====================================

# axi_s2mm_interface

Receive-side counterpart of the team's AXI4-lite-to-stream block. Accepts one frame of 1-4 32-bit words on an AXI4-stream slave port, stores the words in four data registers, and exposes them plus control/status to the PS over an AXI4-lite slave. It sits at the output of the stream datapath (e.g. after the multiplier) so software can read back processed frames.

## Interface
Parameters:
- none (address decode width fixed at 8 bits, data width fixed at 32)

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_axi_awready/awaddr/awvalid  out/in/in  1/32/1  AXI4-lite write address
- s_axi_wready/wdata/wstrb/wvalid  out/in/in/in  1/32/4/1  write data
- s_axi_bready/bresp/bvalid  in/out/out  1/2/1  write response, bresp always 2'b00
- s_axi_arready/araddr/arvalid  out/in/in  1/32/1  read address
- s_axi_rready/rdata/rresp/rvalid  in/out/out/out  1/32/2/1  read data, rresp always 2'b00
- s_axis_tready  out  1  stream ready
- s_axis_tdata  in  32  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  end of frame marker
- en  out  1  CTRL.EN mirrored to datapath
- irq  out  1  level, equals CTRL.DONE

## Operation
Register map (addr[7:0]):
- 0x00 CTRL: [10:8] WORD (R/W, 1-4 valid), [11] EN (R/W), [12] BUSY (R), [13] DONE (R, write 1 clears), [14] ERR (R, write 1 clears), others read 0
- 0x04/0x08/0x0C/0x10 DATA0-3: read-only received words; writes ignored, still get OKAY response
- unmapped reads return 0
- WORD/EN writes honour wstrb bytes; DONE/ERR clear requires wstrb[1]=1 and wdata bit set

AXI4-lite FSMs:
- write: WRIDLE (awready=1) -> WRDATA on awvalid, latch awaddr[7:0]; WRDATA (wready=1) -> WRRESP on wvalid, register updated that cycle; WRRESP (bvalid=1) -> WRIDLE on bready
- read: RDIDLE (arready=1) -> RDDATA on arvalid, rdata registered from araddr that cycle; RDDATA (rvalid=1) -> RDIDLE on rready

Stream FSM:
- IDLE: tready=0; if EN=1, DONE=0, WORD in 1..4 -> RECV, latch WORD into frame length, ptr=0
- RECV: tready=1, BUSY=1; on tvalid&tready write DATA[ptr]<=tdata
  - ptr==len-1: -> FULL, DONE<=1, ERR<=1 if tlast=0
  - ptr<len-1 and tlast=1: early end -> FULL, DONE<=1, ERR<=1; unwritten DATA regs keep old values
  - else ptr<=ptr+1
  - EN written 0: -> IDLE, ptr=0, DONE/ERR unchanged, partial words kept
- FULL: tready=0; when DONE cleared by software -> IDLE (re-arms next cycle if EN=1)
- WORD changes during RECV do not affect current frame
- DONE set and DONE clear cannot coincide (set only in RECV, clear effective only in FULL; W1C in other states is no-op for DONE, still clears ERR)

## Timing
- reset: all AXI FSMs idle, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rdata=0, CTRL=0, DATA0-3=0, ptr=0, stream FSM IDLE, tready=0, en=0, irq=0
- tready is a decode of registered state; no combinational path from tvalid
- EN write completes in cycle N -> IDLE->RECV at N+1 -> tready=1 from cycle N+2
- last beat accepted cycle M -> DONE/irq=1 and tready=0 from M+1
- read latency: rvalid one cycle after ar handshake; write: bvalid one cycle after w handshake
- sustained 1 beat/cycle in RECV

## Test plan
- Reset: hold areset 2 cycles -> tready=0, irq=0, read 0x00 returns 0, DATA0-3 read 0
- WORD=3,EN=1; stream 0x11,0x22,0x33 with tlast on 3rd, back-to-back -> DONE=1, ERR=0, irq=1, DATA0-2 = 0x11/0x22/0x33, tready=0 after last beat
- WORD=2; stream 0xA then 0xB with tlast=0 on 2nd -> DONE=1, ERR=1; write 0x6000 to CTRL -> DONE=0, ERR=0, next frame accepted
- WORD=4; tlast on 2nd beat (0x5,0x6) -> DONE=1, ERR=1, DATA0/1=0x5/0x6, DATA2/3 unchanged
- WORD=4; tvalid toggling every other cycle, then EN=0 after 2 beats -> returns to IDLE, tready=0, DONE=0, BUSY=0
- WORD=0, EN=1 -> stays IDLE, tready=0; write to 0x04 -> bresp OKAY, DATA0 unchanged

Source files
------------

// File: rtl/axi_s2mm_interface.sv
`default_nettype none
// ============================================================================
// Module      : axi_s2mm_interface
// Description : Stream-to-register receiver. Captures one frame of 1-4
//               32-bit words from an AXI4-stream slave into DATA0-3 and
//               exposes them, together with CTRL/status, on an AXI4-lite
//               slave.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_s2mm_interface (
    input  logic        aclk,
    input  logic        areset,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        en,
    output logic        irq
);

    localparam logic [7:0] c_ADDR_CTRL  = 8'h00;
    localparam logic [7:0] c_ADDR_DATA0 = 8'h04;
    localparam logic [7:0] c_ADDR_DATA1 = 8'h08;
    localparam logic [7:0] c_ADDR_DATA2 = 8'h0C;
    localparam logic [7:0] c_ADDR_DATA3 = 8'h10;

    typedef enum logic [1:0] {WRIDLE = 2'd0, WRDATA = 2'd1, WRRESP = 2'd2} wr_state_t;
    typedef enum logic       {RDIDLE = 1'b0, RDDATA = 1'b1} rd_state_t;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_FULL = 2'd2} st_state_t;

    wr_state_t   r_wr_state_q, w_wr_state_d;
    rd_state_t   r_rd_state_q, w_rd_state_d;
    st_state_t   r_st_state_q, w_st_state_d;
    logic [7:0]  r_waddr_q, w_waddr_d;
    logic [31:0] r_rdata_q, w_rdata_d;
    logic [2:0]  r_word_q, w_word_d;
    logic        r_en_q, w_en_d;
    logic        r_done_q, w_done_d;
    logic        r_err_q, w_err_d;
    logic [2:0]  r_len_q, w_len_d;
    logic [1:0]  r_ptr_q, w_ptr_d;
    logic [31:0] r_data_q [4];
    logic [31:0] w_data_d [4];

    logic        w_ctrl_wr;
    logic        w_word_ok;
    logic        w_last_slot;
    logic [31:0] w_ctrl_rd;
    logic        w_unused;

    // Only the low address byte and the CTRL byte-1 fields are decoded
    assign w_unused = &{1'b0, s_axi_awaddr[31:8], s_axi_araddr[31:8],
                        s_axi_wdata[31:15], s_axi_wdata[12], s_axi_wdata[7:0],
                        s_axi_wstrb[3:2], s_axi_wstrb[0]};

    assign s_axi_awready = (r_wr_state_q == WRIDLE);
    assign s_axi_wready  = (r_wr_state_q == WRDATA);
    assign s_axi_bvalid  = (r_wr_state_q == WRRESP);
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = (r_rd_state_q == RDIDLE);
    assign s_axi_rvalid  = (r_rd_state_q == RDDATA);
    assign s_axi_rresp   = 2'b00;
    assign s_axi_rdata   = r_rdata_q;

    // tready decodes registered state only; dropping EN stops acceptance at once
    assign s_axis_tready = (r_st_state_q == S_RECV) && r_en_q;
    assign en            = r_en_q;
    assign irq           = r_done_q;

    // All CTRL fields live in byte 1, so byte-1 strobe gates every CTRL write
    assign w_ctrl_wr   = (r_wr_state_q == WRDATA) && s_axi_wvalid &&
                         (r_waddr_q == c_ADDR_CTRL) && s_axi_wstrb[1];
    assign w_word_ok   = (r_word_q != 3'd0) && (r_word_q <= 3'd4);
    assign w_last_slot = ({1'b0, r_ptr_q} == (r_len_q - 3'd1));
    assign w_ctrl_rd   = {17'd0, r_err_q, r_done_q, (r_st_state_q == S_RECV),
                          r_en_q, r_word_q, 8'h00};

    // AXI4-lite write channel sequencing: address, then data, then response
    always_comb begin
        w_wr_state_d = r_wr_state_q;
        w_waddr_d    = r_waddr_q;
        case (r_wr_state_q)
            WRIDLE: if (s_axi_awvalid) begin
                w_wr_state_d = WRDATA;
                w_waddr_d    = s_axi_awaddr[7:0];
            end
            WRDATA: if (s_axi_wvalid) w_wr_state_d = WRRESP;
            WRRESP: if (s_axi_bready) w_wr_state_d = WRIDLE;
            default: w_wr_state_d = WRIDLE;
        endcase
    end

    // AXI4-lite read channel: read data captured at the address handshake
    always_comb begin
        w_rd_state_d = r_rd_state_q;
        w_rdata_d    = r_rdata_q;
        case (r_rd_state_q)
            RDIDLE: if (s_axi_arvalid) begin
                w_rd_state_d = RDDATA;
                case (s_axi_araddr[7:0])
                    c_ADDR_CTRL:  w_rdata_d = w_ctrl_rd;
                    c_ADDR_DATA0: w_rdata_d = r_data_q[0];
                    c_ADDR_DATA1: w_rdata_d = r_data_q[1];
                    c_ADDR_DATA2: w_rdata_d = r_data_q[2];
                    c_ADDR_DATA3: w_rdata_d = r_data_q[3];
                    default:      w_rdata_d = 32'h0;
                endcase
            end
            RDDATA: if (s_axi_rready) w_rd_state_d = RDIDLE;
            default: w_rd_state_d = RDIDLE;
        endcase
    end

    // Control register updates and the frame-capture state machine
    always_comb begin
        w_st_state_d = r_st_state_q;
        w_word_d     = r_word_q;
        w_en_d       = r_en_q;
        w_done_d     = r_done_q;
        w_err_d      = r_err_q;
        w_len_d      = r_len_q;
        w_ptr_d      = r_ptr_q;
        for (int i = 0; i < 4; i++) w_data_d[i] = r_data_q[i];

        if (w_ctrl_wr) begin
            w_word_d = s_axi_wdata[10:8];
            w_en_d   = s_axi_wdata[11];
            if (s_axi_wdata[14]) w_err_d = 1'b0;
            // DONE can only be set in RECV, so clearing it only in FULL avoids a collision
            if (s_axi_wdata[13] && (r_st_state_q == S_FULL)) w_done_d = 1'b0;
        end

        case (r_st_state_q)
            S_IDLE: if (r_en_q && !r_done_q && w_word_ok) begin
                w_st_state_d = S_RECV;
                w_len_d      = r_word_q;
                w_ptr_d      = 2'd0;
            end
            S_RECV: begin
                if (!r_en_q) begin
                    w_st_state_d = S_IDLE;
                    w_ptr_d      = 2'd0;
                end else if (s_axis_tvalid) begin
                    w_data_d[r_ptr_q] = s_axis_tdata;
                    if (w_last_slot || s_axis_tlast) begin
                        w_st_state_d = S_FULL;
                        w_done_d     = 1'b1;
                        // Error unless the frame ends exactly on the expected word
                        if (!(w_last_slot && s_axis_tlast)) w_err_d = 1'b1;
                    end else begin
                        w_ptr_d = r_ptr_q + 2'd1;
                    end
                end
            end
            S_FULL: if (!r_done_q) w_st_state_d = S_IDLE;
            default: w_st_state_d = S_IDLE;
        endcase
    end

    // State and register storage
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_state_q <= WRIDLE;
            r_rd_state_q <= RDIDLE;
            r_st_state_q <= S_IDLE;
            r_waddr_q    <= 8'h00;
            r_rdata_q    <= 32'h0;
            r_word_q     <= 3'd0;
            r_en_q       <= 1'b0;
            r_done_q     <= 1'b0;
            r_err_q      <= 1'b0;
            r_len_q      <= 3'd0;
            r_ptr_q      <= 2'd0;
            for (int i = 0; i < 4; i++) r_data_q[i] <= 32'h0;
        end else begin
            r_wr_state_q <= w_wr_state_d;
            r_rd_state_q <= w_rd_state_d;
            r_st_state_q <= w_st_state_d;
            r_waddr_q    <= w_waddr_d;
            r_rdata_q    <= w_rdata_d;
            r_word_q     <= w_word_d;
            r_en_q       <= w_en_d;
            r_done_q     <= w_done_d;
            r_err_q      <= w_err_d;
            r_len_q      <= w_len_d;
            r_ptr_q      <= w_ptr_d;
            for (int i = 0; i < 4; i++) r_data_q[i] <= w_data_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_s2mm_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_s2mm_interface
// Description : Self-checking bench for axi_s2mm_interface. Register reads
//               are predicted by a frame-level model and queued; a monitor
//               compares each read response against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_s2mm_interface;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axi_awready, s_axi_awvalid;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_wready, s_axi_wvalid;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bready, s_axi_bvalid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arready, s_axi_arvalid;
    logic [31:0] s_axi_araddr;
    logic        s_axi_rready, s_axi_rvalid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axis_tready, s_axis_tvalid, s_axis_tlast;
    logic [31:0] s_axis_tdata;
    logic        en, irq;

    always #5 aclk = ~aclk;

    axi_s2mm_interface u_dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .en(en), .irq(irq)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];

    // Frame-level reference model
    logic [31:0] m_data [4];
    logic [2:0]  m_word  = 3'd0;
    logic        m_en    = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_err   = 1'b0;
    logic        m_armed = 1'b0;
    int          m_len   = 0;
    int          m_cnt   = 0;

    int   ncyc     = 0;
    int   w_hs_cyc = 0;
    int   rise_cyc = -1;
    logic tready_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_try_arm();
        if (!m_armed && !m_done && m_en && m_word >= 3'd1 && m_word <= 3'd4) begin
            m_armed = 1'b1;
            m_len   = int'(m_word);
            m_cnt   = 0;
        end
    endfunction

    function automatic void m_ctrl_write(input logic [31:0] d, input logic [3:0] s);
        if (s[1]) begin
            m_word = d[10:8];
            m_en   = d[11];
            if (d[14]) m_err  = 1'b0;
            if (d[13]) m_done = 1'b0;
        end
        if (!m_en) begin
            m_armed = 1'b0;
            m_cnt   = 0;
        end
        m_try_arm();
    endfunction

    function automatic void m_beat(input logic [31:0] d, input logic last);
        m_data[m_cnt] = d;
        m_cnt++;
        if (m_cnt == m_len || last) begin
            m_done  = 1'b1;
            m_err   = m_err | !(m_cnt == m_len && last);
            m_armed = 1'b0;
        end
    endfunction

    function automatic logic [31:0] m_reg(input logic [7:0] a);
        case (a)
            8'h00:   return {17'd0, m_err, m_done, m_armed, m_en, m_word, 8'h00};
            8'h04:   return m_data[0];
            8'h08:   return m_data[1];
            8'h0C:   return m_data[2];
            8'h10:   return m_data[3];
            default: return 32'h0;
        endcase
    endfunction

    // Read-response scoreboard
    always @(negedge aclk) begin
        if (s_axi_rvalid && s_axi_rready) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", s_axi_rvalid, 1'b0);
            end else begin
                check("rdata", s_axi_rdata, exp_q.pop_front());
                check("rresp", {30'd0, s_axi_rresp}, 32'd0);
            end
        end
    end

    // Stream beat monitor feeding the model
    always @(negedge aclk) begin
        if (!areset && s_axis_tvalid && s_axis_tready) begin
            check("beat_when_armed", s_axis_tready, m_armed);
            if (m_armed) m_beat(s_axis_tdata, s_axis_tlast);
        end
    end

    // Cycle bookkeeping for latency checks
    always @(negedge aclk) begin
        ncyc = ncyc + 1;
        if (s_axi_wvalid && s_axi_wready) w_hs_cyc = ncyc;
        if (s_axis_tready && !tready_prev) rise_cyc = ncyc;
        tready_prev = s_axis_tready;
    end

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int settle);
        int t;
        s_axi_awaddr  = {24'h0, a};
        s_axi_awvalid = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!s_axi_awready && t < 50);
        check("awready_wait", s_axi_awready, 1'b1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_wvalid  = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!s_axi_wready && t < 50);
        check("wready_wait", s_axi_wready, 1'b1);
        if (a == 8'h00) m_ctrl_write(d, s);
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
        t = 0;
        do begin @(negedge aclk); t++; end while (!s_axi_bvalid && t < 50);
        check("b_latency", 32'(t), 32'd1);
        check("bresp", {30'd0, s_axi_bresp}, 32'd0);
        @(posedge aclk); #1;
        if (settle > 0) begin
            repeat (settle) @(posedge aclk);
            #1;
        end
    endtask

    task automatic axi_read(input logic [7:0] a);
        int t;
        exp_q.push_back(m_reg(a));
        s_axi_araddr  = {24'h0, a};
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        t = 0;
        do begin @(negedge aclk); t++; end while (!s_axi_arready && t < 50);
        check("arready_wait", s_axi_arready, 1'b1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        t = 0;
        do begin @(negedge aclk); t++; end while (!s_axi_rvalid && t < 50);
        check("r_latency", 32'(t), 32'd1);
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 random idle cycles, 2 one idle cycle between beats
    task automatic send_frame(input int nbeats, input int last_at, input int gap_mode,
                              input bit fixed, input logic [31:0] base, input logic [31:0] step);
        int t;
        for (int i = 0; i < nbeats; i++) begin
            if ((gap_mode == 1 && $urandom_range(0, 1) == 1) || (gap_mode == 2 && i > 0)) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk); #1;
            end
            s_axis_tdata  = fixed ? base + step * i : $urandom;
            s_axis_tlast  = (i == last_at);
            s_axis_tvalid = 1'b1;
            t = 0;
            do begin @(negedge aclk); t++; end while (!s_axis_tready && t < 100);
            check("tready_wait", s_axis_tready, 1'b1);
            @(posedge aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge aclk);
        check("irq_after_frame", irq, m_done);
        if (m_done) check("tready_after_last", s_axis_tready, 1'b0);
        @(posedge aclk); #1;
    endtask

    task automatic read_all();
        for (int r = 0; r < 5; r++) axi_read(8'(r * 4));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) m_data[i] = 32'h0;
        areset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 32'h0;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_bready  = 1'b1;
        s_axi_arvalid = 1'b0; s_axi_araddr = 32'h0; s_axi_rready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 32'h0; s_axis_tlast = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;

        // Reset state
        @(negedge aclk);
        check("rst_tready", s_axis_tready, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_en", en, 1'b0);
        check("rst_awready", s_axi_awready, 1'b1);
        check("rst_arready", s_axi_arready, 1'b1);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        @(posedge aclk); #1;
        read_all();

        // WORD=3 frame, back-to-back, tlast on third beat; EN-to-tready latency
        rise_cyc = -1;
        axi_write(8'h00, 32'h0000_0B00, 4'b0010, 3);
        check("en_to_tready", 32'(rise_cyc - w_hs_cyc), 32'd2);
        check("en_out", en, 1'b1);
        send_frame(3, 2, 0, 1'b1, 32'h11, 32'h11);
        read_all();
        axi_write(8'h00, 32'h0000_6000, 4'b0010, 3);

        // WORD=2 without tlast -> error, then clear and re-arm
        axi_write(8'h00, 32'h0000_0A00, 4'b0010, 3);
        send_frame(2, -1, 0, 1'b1, 32'hA, 32'h1);
        axi_read(8'h00);
        axi_write(8'h00, 32'h0000_6A00, 4'b0010, 3);
        axi_read(8'h00);
        send_frame(2, 1, 0, 1'b0, 32'h0, 32'h0);
        read_all();
        axi_write(8'h00, 32'h0000_6000, 4'b0010, 3);

        // WORD=4 with early tlast on the second beat
        axi_write(8'h00, 32'h0000_0C00, 4'b0010, 3);
        send_frame(2, 1, 0, 1'b1, 32'h5, 32'h1);
        read_all();
        axi_write(8'h00, 32'h0000_6000, 4'b0010, 3);

        // WORD=4, tvalid toggling, abort with EN=0 after two beats
        axi_write(8'h00, 32'h0000_0C00, 4'b0010, 3);
        send_frame(2, -1, 2, 1'b0, 32'h0, 32'h0);
        axi_write(8'h00, 32'h0000_0400, 4'b0010, 3);
        check("abort_tready", s_axis_tready, 1'b0);
        read_all();

        // Writes without byte-1 strobe leave CTRL alone
        axi_write(8'h00, 32'h0000_0B00, 4'b1101, 3);
        axi_read(8'h00);

        // WORD=0 never arms; DATA writes are ignored but acknowledged
        axi_write(8'h00, 32'h0000_0800, 4'b0010, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("word0_tready", s_axis_tready, 1'b0);
        end
        @(posedge aclk); #1;
        axi_write(8'h04, 32'hDEAD_BEEF, 4'b1111, 0);
        axi_read(8'h04);
        axi_read(8'h14);
        axi_read(8'h20);
        axi_write(8'h00, 32'h0000_6000, 4'b0010, 3);

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            int len;
            int mode;
            int k;
            len  = $urandom_range(1, 4);
            mode = $urandom_range(0, 2);
            axi_write(8'h00, {20'd0, 1'b1, 3'(len), 8'h00}, 4'b0010, 3);
            if (mode == 0) begin
                send_frame(len, len - 1, $urandom_range(0, 1), 1'b0, 32'h0, 32'h0);
            end else if (mode == 1) begin
                send_frame(len, -1, $urandom_range(0, 1), 1'b0, 32'h0, 32'h0);
            end else begin
                k = (len > 1) ? $urandom_range(0, len - 2) : 0;
                send_frame(k + 1, k, $urandom_range(0, 1), 1'b0, 32'h0, 32'h0);
            end
            read_all();
            axi_write(8'h00, 32'h0000_6000, 4'b0010, 3);
            axi_read(8'h00);
        end

        repeat (3) @(posedge aclk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
